// File: rtl/dec_pkg.sv
// ---------------------------------------------------------------------------
// dec_pkg
// Shared definitions for the decimator serial-output controller:
//   - default widths and timing constants
//   - controller FSM state encoding
// No ports (package).
// ---------------------------------------------------------------------------
package dec_pkg;

    localparam int DEF_DATA_W   = 22;
    localparam int DEF_SETTLE_N = 8;
    localparam int DEF_CLK_DIV  = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_WAIT   = 2'd2,
        S_SHIFT  = 2'd3
    } dec_state_t;

endpackage

// File: rtl/dec_ser_shifter.sv
// ---------------------------------------------------------------------------
// dec_ser_shifter
// Bit timing and MSB-first shift register for one serial frame.
// A frame is DATA_W bits of CLK_DIV cycles each; ser_clk is low for the
// first half of every bit and high for the second half. After the last bit
// the shifter spends exactly one idle "gap" cycle, flagged by frame_done,
// during which the controller may load the next word.
// Ports:
//   clk        - clock
//   srst       - synchronous active-high reset
//   abort      - drop the current frame immediately (outputs low next cycle)
//   load       - start a new frame with load_data on the next cycle
//   load_data  - word to transmit
//   ser_clk    - serial bit clock
//   ser_data   - serial data, MSB first
//   ser_frame  - high for every bit of the frame
//   frame_done - high during the one-cycle gap after the last bit
// ---------------------------------------------------------------------------
module dec_ser_shifter
    import dec_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              abort,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              ser_clk,
    output logic              ser_data,
    output logic              ser_frame,
    output logic              frame_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [DIV_W-1:0]  div_reg, div_next;
    logic [BIT_W-1:0]  bit_reg, bit_next;
    logic              active_reg, active_next;
    logic              gap_reg, gap_next;
    logic              bit_done;
    logic              last_bit;

    assign bit_done = active_reg && (div_reg == DIV_LAST);
    assign last_bit = (bit_reg == BIT_LAST);

    always_comb begin
        shift_next  = shift_reg;
        div_next    = div_reg;
        bit_next    = bit_reg;
        active_next = active_reg;
        gap_next    = 1'b0;
        if (abort) begin
            shift_next  = '0;
            div_next    = '0;
            bit_next    = '0;
            active_next = 1'b0;
        end else if (load) begin
            shift_next  = load_data;
            div_next    = '0;
            bit_next    = '0;
            active_next = 1'b1;
        end else if (active_reg) begin
            if (bit_done) begin
                div_next   = '0;
                shift_next = {shift_reg[DATA_W-2:0], 1'b0};
                if (last_bit) begin
                    // Last bit finished: drop the frame for one gap cycle.
                    active_next = 1'b0;
                    gap_next    = 1'b1;
                    bit_next    = '0;
                end else begin
                    bit_next = bit_reg + 1'b1;
                end
            end else begin
                div_next = div_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            shift_reg  <= '0;
            div_reg    <= '0;
            bit_reg    <= '0;
            active_reg <= 1'b0;
            gap_reg    <= 1'b0;
        end else begin
            shift_reg  <= shift_next;
            div_reg    <= div_next;
            bit_reg    <= bit_next;
            active_reg <= active_next;
            gap_reg    <= gap_next;
        end
    end

    // All outputs are forced low whenever no frame is on the wire.
    assign ser_frame  = active_reg;
    assign ser_data   = active_reg & shift_reg[DATA_W-1];
    assign ser_clk    = active_reg && (div_reg >= DIV_HALF);
    assign frame_done = gap_reg;

endmodule

// File: rtl/dec_ser_ctrl.sv
// ---------------------------------------------------------------------------
// dec_ser_ctrl
// Serialises signed decimator samples. After enable, the first SETTLE_N
// filter outputs are discarded; afterwards each sample is shifted out MSB
// first. Samples arriving while a frame is on the wire go to a single-entry
// hold register (newest wins, loss flagged on ovf).
// Ports:
//   clk_fs       - sole clock
//   rst_b        - synchronous active-high reset
//   en           - controller enable; dropping it aborts any activity
//   sample_in    - signed decimator sample
//   sample_valid - one-cycle strobe qualifying sample_in
//   ovf_clr      - clears ovf (a simultaneous overflow keeps it set)
//   ser_clk      - serial bit clock
//   ser_data     - serial data, MSB first
//   ser_frame    - high for every bit of a frame
//   busy         - frame in progress or sample pending (registered)
//   ovf          - sticky sample-loss flag
// ---------------------------------------------------------------------------
module dec_ser_ctrl
    import dec_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SETTLE_N = DEF_SETTLE_N,
    parameter int CLK_DIV  = DEF_CLK_DIV
) (
    input  logic              clk_fs,
    input  logic              rst_b,
    input  logic              en,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              ovf_clr,
    output logic              ser_clk,
    output logic              ser_data,
    output logic              ser_frame,
    output logic              busy,
    output logic              ovf
);

    localparam int CNT_W = (SETTLE_N > 0) ? $clog2(SETTLE_N + 1) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_N > 0) ? SETTLE_N - 1 : 0);

    dec_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  settle_reg, settle_next;
    logic [DATA_W-1:0] hold_reg, hold_next;
    logic              hold_valid_reg, hold_valid_next;
    logic              ovf_reg, ovf_next;
    logic              busy_reg, busy_next;
    logic              ovf_set;
    logic              load;
    logic [DATA_W-1:0] load_data;
    logic              abort;
    logic              frame_done;

    always_comb begin
        state_next      = state_reg;
        settle_next     = settle_reg;
        hold_next       = hold_reg;
        hold_valid_next = hold_valid_reg;
        ovf_set         = 1'b0;
        load            = 1'b0;
        load_data       = sample_in;
        abort           = 1'b0;

        if ((state_reg != S_IDLE) && !en) begin
            // Abort: the frame is cut and any pending sample is dropped,
            // but the loss history in ovf is kept.
            abort           = 1'b1;
            state_next      = S_IDLE;
            hold_valid_next = 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (en) begin
                        settle_next = '0;
                        state_next  = (SETTLE_N == 0) ? S_WAIT : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (sample_valid) begin
                        if (settle_reg == SETTLE_LAST) begin
                            state_next = S_WAIT;
                        end else begin
                            settle_next = settle_reg + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (sample_valid) begin
                        load       = 1'b1;
                        load_data  = sample_in;
                        state_next = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (frame_done) begin
                        // Gap cycle: a strobe arriving right now is the
                        // newest sample, so it is sent in place of any held one.
                        if (sample_valid) begin
                            load            = 1'b1;
                            load_data       = sample_in;
                            ovf_set         = hold_valid_reg;
                            hold_valid_next = 1'b0;
                        end else if (hold_valid_reg) begin
                            load            = 1'b1;
                            load_data       = hold_reg;
                            hold_valid_next = 1'b0;
                        end else begin
                            state_next = S_WAIT;
                        end
                    end else if (sample_valid) begin
                        hold_next       = sample_in;
                        hold_valid_next = 1'b1;
                        ovf_set         = hold_valid_reg;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end

        ovf_next  = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_reg);
        busy_next = (state_next == S_SHIFT) || hold_valid_next;
    end

    always_ff @(posedge clk_fs) begin
        if (rst_b) begin
            state_reg      <= S_IDLE;
            settle_reg     <= '0;
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            ovf_reg        <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            settle_reg     <= settle_next;
            hold_reg       <= hold_next;
            hold_valid_reg <= hold_valid_next;
            ovf_reg        <= ovf_next;
            busy_reg       <= busy_next;
        end
    end

    dec_ser_shifter #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk        (clk_fs),
        .srst       (rst_b),
        .abort      (abort),
        .load       (load),
        .load_data  (load_data),
        .ser_clk    (ser_clk),
        .ser_data   (ser_data),
        .ser_frame  (ser_frame),
        .frame_done (frame_done)
    );

    assign busy = busy_reg;
    assign ovf  = ovf_reg;

endmodule
